i_sram_axi_bridge: RTL and testbench

I_SRAM_AXI_BRIDGE -- requirements
Module: i_sram_axi_bridge

---
 rtl/sram_axi_pkg.sv | 17 +
 rtl/i_sram_axi_bridge.sv | 130 +++++++++++++
 tb/tb_i_sram_axi_bridge.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_axi_pkg.sv
// Shared definitions for the SRAM-like to AXI read bridge: FSM encoding and
// the fixed AXI field values used on the read address channel.
package sram_axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [3:0] AXI_DEFAULT_ID = 4'd0;
  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;

endpackage

// File: rtl/i_sram_axi_bridge.sv
// SRAM-like request port to AXI read channel bridge. One request in flight;
// reads become a single-beat INCR burst, writes complete at once with an error.
module i_sram_axi_bridge
  import sram_axi_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata,
  output logic        err,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata_axi,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  state_t      state_q;
  state_t      state_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        rd_accept;
  logic        wr_accept;
  logic        r_fire;

  // Write data, strobes, read ID and last flag carry no information for a
  // read-only single-beat bridge.
  logic unused_ok;
  assign unused_ok = ^{wstrb, wdata, rid, rlast};

  assign rd_accept = (state_q == IDLE) && req && !wr;
  assign wr_accept = (state_q == IDLE) && req && wr;
  assign r_fire    = (state_q == R) && rvalid;

  // State register; reset abandons any AXI transaction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode and handshake strobes.
  always_comb begin
    state_d = state_q;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    arvalid = 1'b0;
    rready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (wr) begin
            // Writes are refused immediately; no AXI traffic.
            addr_ok = 1'b1;
            state_d = RESP;
          end else begin
            state_d = AR;
          end
        end
      end
      AR: begin
        arvalid = 1'b1;
        addr_ok = arready;
        if (arready) state_d = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) state_d = RESP;
      end
      RESP: begin
        data_ok = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the read request so AR fields stay stable while arready is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      size_q <= '0;
    end else if (rd_accept) begin
      addr_q <= addr;
      size_q <= size;
    end
  end

  // Capture the completion; values persist until the next completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (wr_accept) begin
      rdata_q <= '0;
      err_q   <= 1'b1;
    end else if (r_fire) begin
      rdata_q <= rdata_axi;
      err_q   <= (rresp != AXI_RESP_OKAY);
    end
  end

  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arid    = AXI_DEFAULT_ID;
  assign rdata   = rdata_q;
  assign err     = err_q;

endmodule

// File: tb/tb_i_sram_axi_bridge.sv
// Bench for i_sram_axi_bridge: a master issues requests and pushes expected
// completions into a queue, an AXI slave model answers from its own queue,
// and a monitor pops and compares whenever data_ok is seen.
module tb_i_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata_axi;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  i_sram_axi_bridge dut (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr),
    .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
    .rdata(rdata), .err(err), .arid(arid), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata_axi(rdata_axi), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] beat;
    logic [1:0]  resp;
    int          ar_delay;
    int          r_delay;
  } slv_t;

  typedef struct {
    logic        err;
    logic [31:0] data;
  } rsp_t;

  slv_t sq[$];
  rsp_t eq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;
  int ar_cycles = 0;
  int last_aok_cyc = 0;
  int last_dok_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // Monitor: scoreboard pop on every completion plus per-cycle protocol rules.
  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("aok_dok_exclusive", {63'd0, addr_ok & data_ok}, 64'd0);
        if (data_ok) begin
          last_dok_cyc = cyc;
          if (eq.size() == 0) begin
            fail_now("unexpected_data_ok");
          end else begin
            e = eq.pop_front();
            check("rdata", rdata, e.data);
            check("err", err, e.err);
          end
          done_cnt++;
        end
        if (arvalid) begin
          ar_cycles++;
          check("arid", arid, 0);
          check("arlen", arlen, 0);
          check("arburst", arburst, 2'b01);
          check("rready_not_in_ar", rready, 0);
        end
      end
    end
  end

  // AXI slave model driven from the queue of planned read beats.
  initial begin : slave
    slv_t        cur;
    int          phase;
    int          arcnt;
    int          rcnt;
    logic        ar_fire;
    logic        r_fire;
    logic        rst_s;
    logic        stall_s;
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [2:0]  prev_size;
    arready = 1'b0; rvalid = 1'b0; rdata_axi = '0; rresp = '0; rid = '0; rlast = 1'b0;
    phase = 0; arcnt = 0; rcnt = 0; prev_stall = 1'b0;
    prev_addr = '0; prev_size = '0;
    forever begin
      @(negedge clk);
      rst_s   = rst;
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      stall_s = !rst && arvalid && !arready;
      if (!rst_s) begin
        if (prev_stall) begin
          check("ar_hold_valid", arvalid, 1);
          check("ar_hold_addr", araddr, prev_addr);
          check("ar_hold_size", arsize, prev_size);
        end
        if (arvalid) begin
          if (sq.size() == 0) begin
            fail_now("unexpected_arvalid");
          end else begin
            check("araddr", araddr, sq[0].addr);
            check("arsize", arsize, {1'b0, sq[0].size});
          end
        end
      end
      prev_stall = stall_s;
      prev_addr  = araddr;
      prev_size  = arsize;
      @(posedge clk); #1;
      if (rst_s) begin
        sq.delete();
        phase = 0; arcnt = 0; rcnt = 0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      end else begin
        if (phase == 1) begin
          if (r_fire) begin
            phase = 0;
            rvalid = 1'b0; rlast = 1'b0;
            rdata_axi = $urandom; rresp = 2'($urandom_range(0, 3));
          end else begin
            rcnt++;
          end
        end else if (ar_fire) begin
          cur = sq.pop_front();
          phase = 1; rcnt = 0; arcnt = 0;
        end else if (stall_s) begin
          arcnt++;
        end
        if (phase == 0) arready = (sq.size() > 0) && (arcnt >= sq[0].ar_delay);
        else arready = 1'b0;
        if (phase == 1) begin
          if (rcnt >= cur.r_delay) begin
            rvalid = 1'b1; rdata_axi = cur.beat; rresp = cur.resp;
            rid = 4'($urandom_range(0, 15)); rlast = 1'b1;
          end else begin
            rvalid = 1'b0; rdata_axi = $urandom;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (done_cnt < acc_cnt && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < acc_cnt) fail_now("completion_timeout");
    #1;
  endtask

  // Issue one request (called just after a rising edge). With chk set the
  // bridge must be idle, and the accept and response latencies are checked.
  task automatic issue(input bit w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] beat, input logic [1:0] resp,
                       input int ard, input int rd, input bit chk);
    rsp_t e;
    slv_t s;
    int   n;
    bit   got;
    e.err  = w ? 1'b1 : (resp != 2'b00);
    e.data = w ? 32'd0 : beat;
    eq.push_back(e);
    if (!w) begin
      s.addr = a; s.size = sz; s.beat = beat; s.resp = resp;
      s.ar_delay = ard; s.r_delay = rd;
      sq.push_back(s);
    end
    req = 1'b1; wr = w; size = sz; addr = a;
    wstrb = 4'($urandom_range(0, 15)); wdata = $urandom;
    n = 0; got = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (addr_ok) got = 1;
      else n++;
    end
    if (!got) begin
      fail_now("addr_ok_timeout");
    end else begin
      check("one_outstanding", acc_cnt, done_cnt);
      acc_cnt++;
      last_aok_cyc = cyc;
      if (chk) check(w ? "wr_accept_latency" : "rd_accept_latency", n, w ? 0 : 1 + ard);
    end
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0; addr = $urandom; size = 2'($urandom_range(0, 3));
    if (got && chk) begin
      wait_idle();
      check("resp_latency", last_dok_cyc - last_aok_cyc, w ? 1 : 2 + rd);
    end
  endtask

  initial begin : stimulus
    int          arc0;
    bit          b2b;
    bit          w;
    logic [31:0] beat;
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = '0; addr = '0; wstrb = '0; wdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_addr_ok", addr_ok, 0);
    check("rst_data_ok", data_ok, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arsize", arsize, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Minimum-latency boot fetch.
    issue(1'b0, 2'd2, 32'hBFC00000, 32'h3C08BFC0, 2'b00, 0, 0, 1'b1);
    // Slave holds arready low for five cycles.
    issue(1'b0, 2'd1, 32'h1FC0_0102, 32'hA5A5_1234, 2'b00, 5, 1, 1'b1);
    // SLVERR response, then results must hold while idle.
    beat = 32'hDEAD_BEEF;
    issue(1'b0, 2'd0, 32'h0000_0013, beat, 2'b10, 1, 2, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_rdata", rdata, beat);
    check("hold_err", err, 1);
    @(posedge clk); #1;
    // Write request refused without AXI traffic.
    arc0 = ar_cycles;
    issue(1'b1, 2'd2, 32'h8000_0000, 32'd0, 2'b00, 0, 0, 1'b1);
    check("wr_no_ar", ar_cycles, arc0);

    // Reset while waiting in R abandons the read.
    issue(1'b0, 2'd2, 32'h0000_4000, 32'h1111_2222, 2'b00, 0, 20, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstR_rready", rready, 0);
    check("rstR_arvalid", arvalid, 0);
    check("rstR_data_ok", data_ok, 0);
    check("rstR_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    eq.delete();
    acc_cnt = done_cnt;
    repeat (5) begin
      @(negedge clk);
      check("rstR_no_data_ok", data_ok, 0);
    end
    @(posedge clk); #1;
    issue(1'b0, 2'd2, 32'h0000_4004, 32'h7777_8888, 2'b00, 0, 0, 1'b1);

    // Back-to-back reads with req held high.
    issue(1'b0, 2'd2, 32'h0000_1000, 32'hCAFE_0001, 2'b00, 0, 0, 1'b0);
    issue(1'b0, 2'd2, 32'h0000_1004, 32'hCAFE_0002, 2'b01, 0, 0, 1'b0);
    wait_idle();

    // Random mix of reads, writes, delays and back-to-back issue.
    for (int i = 0; i < 60; i++) begin
      b2b = ($urandom_range(0, 2) == 0);
      w   = ($urandom_range(0, 3) == 0);
      if (!b2b) wait_idle();
      issue(w, 2'($urandom_range(0, 2)), $urandom, $urandom,
            2'($urandom_range(0, 3)), $urandom_range(0, 4),
            $urandom_range(0, 4), !b2b);
    end
    wait_idle();
    repeat (3) @(posedge clk);
    if (eq.size() != 0) fail_now("leftover_expected");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
